// File: rtl/pll_mgmt_responder.sv
// Avalon-MM management responder for the video PLL reconfiguration port.
// Shadow N/M/C/BW/CP registers are written over the bus. START runs a timed
// BUSY (reconfigure) then LOCK (relock) sequence. The shadows are copied to
// the active outputs on the last BUSY cycle.
module pll_mgmt_responder #(
  parameter int RECONFIG_CYCLES = 16,
  parameter int LOCK_CYCLES     = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_read,
  input  logic        mgmt_write,
  input  logic [31:0] mgmt_writedata,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  output logic [17:0] active_m,
  output logic [17:0] active_n,
  output logic [17:0] active_c,
  output logic [8:0]  m_div,
  output logic [8:0]  n_div,
  output logic [8:0]  c_div,
  output logic [3:0]  active_bw,
  output logic [2:0]  active_cp,
  output logic        reconfig_busy,
  output logic        pll_locked
);

  localparam int CMAX = (RECONFIG_CYCLES > LOCK_CYCLES) ? RECONFIG_CYCLES : LOCK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [17:0] CNT_RST = 18'h1_0000;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_LOCK} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, locked_q;
  logic            mode_q;
  logic [17:0]     sh_n_q, sh_m_q, sh_c_q;
  logic [3:0]      sh_bw_q;
  logic [2:0]      sh_cp_q;
  logic [17:0]     act_n_q, act_m_q, act_c_q;
  logic [8:0]      div_n_q, div_m_q, div_c_q;
  logic [3:0]      act_bw_q;
  logic [2:0]      act_cp_q;
  logic            stall, wr_acc, start_acc;
  logic            unused_wdata;

  assign unused_wdata = ^mgmt_writedata[31:18];

  // Bypass forces divide-by-one; otherwise the ratio is hi + lo.
  function automatic logic [8:0] div_of(input logic [17:0] w);
    return w[16] ? 9'd1 : ({1'b0, w[15:8]} + {1'b0, w[7:0]});
  endfunction

  // Stall only in waitrequest mode while sequencing; STATUS reads always pass
  assign stall     = ~mode_q & busy_q &
                     (mgmt_write | (mgmt_read & (mgmt_address != 6'h01)));
  assign wr_acc    = mgmt_write & ~stall;
  assign start_acc = wr_acc & (mgmt_address == 6'h02);
  assign mgmt_waitrequest = stall;

  // Zero-latency read mux; reflects pre-write register contents
  always_comb begin
    mgmt_readdata = 32'h0;
    if (mgmt_read) begin
      case (mgmt_address)
        6'h00:   mgmt_readdata = {31'h0, mode_q};
        6'h01:   mgmt_readdata = {31'h0, (state_q == S_IDLE)};
        6'h03:   mgmt_readdata = {14'h0, sh_n_q};
        6'h04:   mgmt_readdata = {14'h0, sh_m_q};
        6'h05:   mgmt_readdata = {14'h0, sh_c_q};
        6'h08:   mgmt_readdata = {28'h0, sh_bw_q};
        6'h09:   mgmt_readdata = {29'h0, sh_cp_q};
        default: mgmt_readdata = 32'h0;
      endcase
    end
  end

  // Bus-writable shadow and mode registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q  <= 1'b0;
      sh_n_q  <= CNT_RST;
      sh_m_q  <= CNT_RST;
      sh_c_q  <= CNT_RST;
      sh_bw_q <= 4'h0;
      sh_cp_q <= 3'h0;
    end else if (wr_acc) begin
      case (mgmt_address)
        6'h00:   mode_q  <= mgmt_writedata[0];
        6'h03:   sh_n_q  <= mgmt_writedata[17:0];
        6'h04:   sh_m_q  <= mgmt_writedata[17:0];
        6'h05:   sh_c_q  <= mgmt_writedata[17:0];
        6'h08:   sh_bw_q <= mgmt_writedata[3:0];
        6'h09:   sh_cp_q <= mgmt_writedata[2:0];
        default: ;
      endcase
    end
  end

  // Reconfig/lock sequencer with registered status and committed outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_LOCK;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      locked_q <= 1'b0;
      act_n_q  <= CNT_RST;
      act_m_q  <= CNT_RST;
      act_c_q  <= CNT_RST;
      div_n_q  <= 9'd1;
      div_m_q  <= 9'd1;
      div_c_q  <= 9'd1;
      act_bw_q <= 4'h0;
      act_cp_q <= 3'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            state_q  <= S_BUSY;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            locked_q <= 1'b0;
          end
        end
        S_BUSY: begin
          if (cnt_q == CW'(RECONFIG_CYCLES - 1)) begin
            // Commit uses the pre-edge shadows, so a same-cycle write misses it
            act_n_q  <= sh_n_q;
            act_m_q  <= sh_m_q;
            act_c_q  <= sh_c_q;
            div_n_q  <= div_of(sh_n_q);
            div_m_q  <= div_of(sh_m_q);
            div_c_q  <= div_of(sh_c_q);
            act_bw_q <= sh_bw_q;
            act_cp_q <= sh_cp_q;
            state_q  <= S_LOCK;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_LOCK: begin
          if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            locked_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= S_LOCK;
          cnt_q    <= '0;
          busy_q   <= 1'b1;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign active_n      = act_n_q;
  assign active_m      = act_m_q;
  assign active_c      = act_c_q;
  assign n_div         = div_n_q;
  assign m_div         = div_m_q;
  assign c_div         = div_c_q;
  assign active_bw     = act_bw_q;
  assign active_cp     = act_cp_q;
  assign reconfig_busy = busy_q;
  assign pll_locked    = locked_q;

endmodule
